mmu_walk_arbiter: RTL

- Shares the single page-table-walk MMU between the instruction TLB and the data TLB.
- Selects one TLB miss at a time and latches its request fields.
- Drives the MMU until the walk completes or is aborted, then routes the result back to the owning TLB.
- Sits between the two TLBs and the MMU. The MMU's L1 arbiter port and its CSR inputs (satp, privilege, sum, mxr) do not pass through this block.

---
 rtl/mmu_walk_arbiter_pkg.sv | 32 +++
 rtl/mmu_walk_arbiter_if.sv | 52 +++++
 rtl/mmu_walk_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mmu_walk_arbiter_pkg.sv
// Shared types for the MMU walk arbiter: the one-hot arbiter state, the
// requester identity used for round-robin bookkeeping, and the grant-pick
// helper used in the IDLE state.
package mmu_walk_arbiter_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    GRANT_I = 4'b0010,
    GRANT_D = 4'b0100,
    RECOVER = 4'b1000
  } mmu_arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } tlb_requester_t;

  // Returns 1 when the data side should win. Only meaningful when at least
  // one side is eligible; the caller gates on that.
  function automatic logic pick_data(
    input logic           i_el,
    input logic           d_el,
    input tlb_requester_t last,
    input logic           fixed_data
  );
    if (!i_el)     return d_el;
    if (!d_el)     return 1'b0;
    if (fixed_data) return 1'b1;
    return (last == INSTR);
  endfunction

endpackage

// File: rtl/mmu_walk_arbiter_if.sv
// Bundle of the TLB-side and MMU-side walk signals around the arbiter.
//   master : arbiter view (drives MMU request fields and TLB result pulses)
//   slave  : environment view (TLBs + MMU)
interface mmu_walk_arbiter_if #(
  parameter int unsigned VA_W  = 32,
  parameter int unsigned UPA_W = 20
);
  logic              itlb_request;
  logic [VA_W-1:0]   itlb_virtual_address;
  logic              itlb_abort;
  logic              itlb_write_entry;
  logic              itlb_is_fault;

  logic              dtlb_request;
  logic [VA_W-1:0]   dtlb_virtual_address;
  logic              dtlb_rnw;
  logic              dtlb_abort;
  logic              dtlb_write_entry;
  logic              dtlb_is_fault;

  logic [UPA_W-1:0]  tlb_upper_physical_address;

  logic              mmu_request;
  logic [VA_W-1:0]   mmu_virtual_address;
  logic              mmu_execute;
  logic              mmu_rnw;
  logic              mmu_abort;
  logic              mmu_write_entry;
  logic              mmu_is_fault;
  logic [UPA_W-1:0]  mmu_upper_physical_address;

  modport master (
    input  itlb_request, itlb_virtual_address, itlb_abort,
    output itlb_write_entry, itlb_is_fault,
    input  dtlb_request, dtlb_virtual_address, dtlb_rnw, dtlb_abort,
    output dtlb_write_entry, dtlb_is_fault,
    output tlb_upper_physical_address,
    output mmu_request, mmu_virtual_address, mmu_execute, mmu_rnw, mmu_abort,
    input  mmu_write_entry, mmu_is_fault, mmu_upper_physical_address
  );

  modport slave (
    output itlb_request, itlb_virtual_address, itlb_abort,
    input  itlb_write_entry, itlb_is_fault,
    output dtlb_request, dtlb_virtual_address, dtlb_rnw, dtlb_abort,
    input  dtlb_write_entry, dtlb_is_fault,
    input  tlb_upper_physical_address,
    input  mmu_request, mmu_virtual_address, mmu_execute, mmu_rnw, mmu_abort,
    output mmu_write_entry, mmu_is_fault, mmu_upper_physical_address
  );

endinterface

// File: rtl/mmu_walk_arbiter.sv
// Arbitrates the single page-table-walk MMU between the instruction and data
// TLBs. One miss is granted at a time; its address/execute/rnw are latched and
// held on the MMU side until the walk completes or is aborted, and the result
// pulse is routed back to the owning TLB only.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - mmu_walk_arbiter_if.master (TLB requests/results, MMU request/result)
module mmu_walk_arbiter
  import mmu_walk_arbiter_pkg::*;
#(
  parameter int          FIXED_DATA_PRIORITY = 0,
  parameter int unsigned VA_W                = 32,
  parameter int unsigned UPA_W               = 20
) (
  input logic               clk,
  input logic               rst_n,
  mmu_walk_arbiter_if.master bus
);

  mmu_arb_state_t  state_q, state_d;
  tlb_requester_t  last_q, last_d;
  logic [VA_W-1:0] addr_q, addr_d;
  logic            exec_q, exec_d;
  logic            rnw_q, rnw_d;

  logic i_el, d_el;
  logic done;

  assign i_el = bus.itlb_request & ~bus.itlb_abort;
  assign d_el = bus.dtlb_request & ~bus.dtlb_abort;
  assign done = bus.mmu_write_entry | bus.mmu_is_fault;

  assign bus.tlb_upper_physical_address = bus.mmu_upper_physical_address;
  assign bus.mmu_request         = (state_q == GRANT_I) || (state_q == GRANT_D);
  assign bus.mmu_virtual_address = addr_q;
  assign bus.mmu_execute         = exec_q;
  assign bus.mmu_rnw             = rnw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= INSTR;
      addr_q  <= '0;
      exec_q  <= 1'b0;
      rnw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      exec_q  <= exec_d;
      rnw_q   <= rnw_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    last_d               = last_q;
    addr_d               = addr_q;
    exec_d               = exec_q;
    rnw_d                = rnw_q;
    bus.mmu_abort        = 1'b0;
    bus.itlb_write_entry = 1'b0;
    bus.itlb_is_fault    = 1'b0;
    bus.dtlb_write_entry = 1'b0;
    bus.dtlb_is_fault    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_el || d_el) begin
          if (pick_data(i_el, d_el, last_q, FIXED_DATA_PRIORITY != 0)) begin
            state_d = GRANT_D;
            last_d  = DATA;
            addr_d  = bus.dtlb_virtual_address;
            exec_d  = 1'b0;
            rnw_d   = bus.dtlb_rnw;
          end else begin
            state_d = GRANT_I;
            last_d  = INSTR;
            addr_d  = bus.itlb_virtual_address;
            exec_d  = 1'b1;
            rnw_d   = 1'b1;
          end
        end
      end
      // Abort is checked first so a coincident completion is never forwarded.
      GRANT_I: begin
        if (bus.itlb_abort || !bus.itlb_request) begin
          bus.mmu_abort = 1'b1;
          state_d       = RECOVER;
        end else if (done) begin
          bus.itlb_write_entry = bus.mmu_write_entry;
          bus.itlb_is_fault    = bus.mmu_is_fault;
          state_d              = IDLE;
        end
      end
      GRANT_D: begin
        if (bus.dtlb_abort || !bus.dtlb_request) begin
          bus.mmu_abort = 1'b1;
          state_d       = RECOVER;
        end else if (done) begin
          bus.dtlb_write_entry = bus.mmu_write_entry;
          bus.dtlb_is_fault    = bus.mmu_is_fault;
          state_d              = IDLE;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A completion outside a grant means the MMU and arbiter disagree on
  // ownership; it is dropped in hardware and flagged in simulation.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == IDLE || state_q == RECOVER)) begin
      assert (!done) else $error("mmu completion pulse with no walk granted");
    end
  end

endmodule
